aes_multi_chan_sched: RTL and testbench

- Parametrised successor to the single-port AES core interface (ld/key/text_in in, done/text_out out).
- Accepts encryption jobs from NUM_CH independent requesters over valid/ready handshakes.
- Arbitrates the jobs round-robin onto one shared AES core that speaks the ld/done protocol.
- Returns each result tagged with its channel index over a valid/ready response port.

---
 rtl/aes_multi_chan_sched.sv | 170 +++++++++++++++++
 tb/tb_aes_multi_chan_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_multi_chan_sched.sv
// Round-robin scheduler that feeds NUM_CH valid/ready requesters into one shared ld/done AES core.
// Define AES_SCHED_TIMEOUT_EN to build the core-timeout abort path (resp_err); otherwise BUSY waits forever.
module aes_multi_chan_sched #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 128,
  parameter int KEY_W       = 128,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*KEY_W-1:0]  req_key,
  input  logic [NUM_CH*DATA_W-1:0] req_text,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [CH_W-1:0]          resp_ch,
  output logic [DATA_W-1:0]        resp_text,
  output logic                     resp_err,
  output logic                     core_ld,
  output logic [KEY_W-1:0]         core_key,
  output logic [DATA_W-1:0]        core_text_in,
  input  logic                     core_done,
  input  logic [DATA_W-1:0]        core_text_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CH_W-1:0]     ptr_r;
  logic [CH_W-1:0]     resp_ch_r;
  logic [CH_W-1:0]     grant_idx_s;
  logic                grant_found_s;
  logic [KEY_W-1:0]    core_key_r;
  logic [DATA_W-1:0]   core_text_r;
  logic [DATA_W-1:0]   resp_text_r;
  logic                timeout_s;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    busy_cnt_r;
  logic                resp_err_r;

  // BUSY-cycle counter, cleared while the load pulse is out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_r <= '0;
    end else if (state_r == LOAD) begin
      busy_cnt_r <= '0;
    end else if (state_r == BUSY) begin
      busy_cnt_r <= busy_cnt_r + CNT_W'(1);
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign timeout_s = (state_r == BUSY) && (busy_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign resp_err  = resp_err_r;
`else
  assign timeout_s = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // Round-robin search: first valid channel at or above ptr, wrapping modulo NUM_CH
  always_comb begin
    logic [CH_W:0] sum_s;
    logic [CH_W:0] cand_s;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s  = {1'b0, ptr_r} + (CH_W+1)'(k);
      cand_s = (sum_s >= (CH_W+1)'(NUM_CH)) ? sum_s - (CH_W+1)'(NUM_CH) : sum_s;
      if (!grant_found_s && req_valid[cand_s[CH_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[CH_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; core_done only counts in BUSY
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = grant_found_s ? LOAD : IDLE;
      LOAD:    state_nxt_s = BUSY;
      BUSY:    state_nxt_s = (core_done || timeout_s) ? RESP : BUSY;
      RESP:    state_nxt_s = resp_ready ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs; req_ready is gated by rst so every output reads 0 during reset
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && grant_found_s && !rst) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    core_ld    = (state_r == LOAD);
    resp_valid = (state_r == RESP);
  end

  // Job datapath: capture request at grant, result at completion, advance pointer on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= '0;
      resp_ch_r   <= '0;
      core_key_r  <= '0;
      core_text_r <= '0;
      resp_text_r <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      resp_err_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            core_key_r  <= req_key[grant_idx_s*KEY_W +: KEY_W];
            core_text_r <= req_text[grant_idx_s*DATA_W +: DATA_W];
            resp_ch_r   <= grant_idx_s;
          end
        end
        BUSY: begin
          if (core_done) begin
            resp_text_r <= core_text_out;
`ifdef AES_SCHED_TIMEOUT_EN
            resp_err_r  <= 1'b0;
          end else if (timeout_s) begin
            resp_text_r <= '0;
            resp_err_r  <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            ptr_r <= (resp_ch_r == CH_W'(NUM_CH - 1)) ? '0 : resp_ch_r + CH_W'(1);
          end
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  assign resp_ch      = resp_ch_r;
  assign resp_text    = resp_text_r;
  assign core_key     = core_key_r;
  assign core_text_in = core_text_r;

endmodule

// File: tb/tb_aes_multi_chan_sched.sv
// Randomized bench for aes_multi_chan_sched: job-level reference model, behavioural core, directed phases.
// Timeout expectations follow AES_SCHED_TIMEOUT_EN when the bench is built with it.
module tb_aes_multi_chan_sched;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 128;
  localparam int KEY_W  = 128;
  localparam int CH_W   = 2;
  localparam int TO     = 64;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*KEY_W-1:0]  req_key;
  logic [NUM_CH*DATA_W-1:0] req_text;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [CH_W-1:0]          resp_ch;
  logic [DATA_W-1:0]        resp_text;
  logic                     resp_err;
  logic                     core_ld;
  logic [KEY_W-1:0]         core_key;
  logic [DATA_W-1:0]        core_text_in;
  logic                     core_done;
  logic [DATA_W-1:0]        core_text_out;

  aes_multi_chan_sched #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEY_W(KEY_W), .CH_W(CH_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_text(req_text),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ch(resp_ch),
    .resp_text(resp_text), .resp_err(resp_err),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // requester side
  logic [NUM_CH-1:0] pend;
  logic [KEY_W-1:0]  pkey  [NUM_CH];
  logic [DATA_W-1:0] ptext [NUM_CH];
  int gen_mode;
  int ready_pct;
  bit rst_req;

  // behavioural core
  int ccnt;
  int core_lat;
  bit rand_lat;
  logic [KEY_W-1:0]  ckey;
  logic [DATA_W-1:0] ctext;

  // job-level reference model
  bit m_active;
  int m_ch, m_gcyc, m_dcyc, m_ptr;
  bit m_err;
  logic [KEY_W-1:0]  m_key;
  logic [DATA_W-1:0] m_text;

  // observation log
  int cyc;
  int glog[$];
  int rlog[$];
  int rdy_cyc, ld_cyc, rv_cyc, hs_cyc;
  bit prev_rv;
  logic [DATA_W-1:0] last_text;
  logic last_err;

  function automatic logic [DATA_W-1:0] core_fn(input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return {t[63:0], t[127:64]} ^ k ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
  endfunction

  function automatic int first_from(input logic [NUM_CH-1:0] v, input int p);
    for (int k = 0; k < NUM_CH; k++) if (v[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NUM_CH-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic new_job(input int ch);
    pend[ch]  = 1'b1;
    pkey[ch]  = {$urandom, $urandom, $urandom, $urandom};
    ptext[ch] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // one clock cycle: drive inputs after negedge, check outputs, update model
  task automatic step();
    int f;
    logic [NUM_CH-1:0] exp_rdy;
    logic exp_ld, exp_rv;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!pend[ch] && (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 3) == 0))) new_job(ch);
      else if (pend[ch] && gen_mode == 1 && $urandom_range(0, 15) == 0) pend[ch] = 1'b0;
      req_key[ch*KEY_W +: KEY_W]    = pkey[ch];
      req_text[ch*DATA_W +: DATA_W] = ptext[ch];
    end
    req_valid  = pend;
    resp_ready = ($urandom_range(0, 99) < ready_pct);
    core_done  = 1'b0;
    if (ccnt > 0) begin
      ccnt--;
      if (ccnt == 0) begin
        core_done     = 1'b1;
        core_text_out = core_fn(ckey, ctext);
      end
    end
    #1;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_ch", resp_ch, 0);
      check("rst_resp_text", resp_text, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_core_ld", core_ld, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_text", core_text_in, 0);
      m_active = 1'b0;
      m_ptr    = 0;
    end else begin
      f = first_from(pend, m_ptr);
      exp_rdy = '0;
      if (!m_active && f >= 0) exp_rdy[f] = 1'b1;
      exp_ld = m_active && (cyc == m_gcyc + 1);
      exp_rv = m_active && (m_dcyc >= 0) && (cyc > m_dcyc);
      check("req_ready", req_ready, exp_rdy);
      check("core_ld", core_ld, exp_ld);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check("resp_ch", resp_ch, m_ch);
        check("resp_text", resp_text, m_err ? '0 : core_fn(m_key, m_text));
        check("resp_err", resp_err, m_err);
      end
      if (m_active && cyc > m_gcyc && m_dcyc < 0) begin
        check("core_key", core_key, m_key);
        check("core_text_in", core_text_in, m_text);
      end
      if (exp_rdy != '0) begin
        m_active = 1'b1;
        m_ch     = f;
        m_gcyc   = cyc;
        m_dcyc   = -1;
        m_err    = 1'b0;
        m_key    = pkey[f];
        m_text   = ptext[f];
      end else if (m_active && m_dcyc < 0 && cyc >= m_gcyc + 2) begin
        if (core_done) m_dcyc = cyc;
        else if (TO_EN && cyc == m_gcyc + 1 + TO) begin
          m_dcyc = cyc;
          m_err  = 1'b1;
        end
      end else if (exp_rv && resp_ready) begin
        m_active = 1'b0;
        m_ptr    = (m_ch + 1) % NUM_CH;
      end
    end
    if (req_ready != '0) begin
      glog.push_back(oh_idx(req_ready));
      rdy_cyc = cyc;
      pend    = pend & ~req_ready;
    end
    if (core_ld) begin
      ld_cyc = cyc;
      ckey   = core_key;
      ctext  = core_text_in;
      ccnt   = rand_lat ? int'($urandom_range(1, 12)) : core_lat;
    end
    if (resp_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = resp_valid;
    if (resp_valid && resp_ready) begin
      rlog.push_back(int'(resp_ch));
      last_text = resp_text;
      last_err  = resp_err;
      hs_cyc    = cyc;
    end
  endtask

  task automatic drain(input int n);
    gen_mode  = 0;
    pend      = '0;
    ready_pct = 100;
    repeat (n) step();
  endtask

  initial begin
    int s;
    rst = 1'b1; rst_req = 1'b1;
    pend = '0; gen_mode = 0; ready_pct = 100;
    req_valid = '0; req_key = '0; req_text = '0; resp_ready = 1'b0;
    core_done = 1'b0; core_text_out = '0;
    ccnt = 0; core_lat = 10; rand_lat = 1'b0; ckey = '0; ctext = '0;
    m_active = 1'b0; m_ch = 0; m_gcyc = 0; m_dcyc = -1; m_ptr = 0; m_err = 1'b0;
    m_key = '0; m_text = '0;
    cyc = 0; rdy_cyc = -1; ld_cyc = -1; rv_cyc = -1; hs_cyc = -1; prev_rv = 1'b0;
    last_text = '0; last_err = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin pkey[ch] = '0; ptext[ch] = '0; end

    repeat (3) step();
    rst_req = 1'b0;
    repeat (2) step();

    // all channels continuously valid: strict rotation from ptr 0
    glog.delete(); rlog.delete();
    rand_lat = 1'b1; gen_mode = 2; s = 0;
    while (glog.size() < 8 && s < 600) begin step(); s++; end
    gen_mode = 0; pend = '0;
    s = 0;
    while (rlog.size() < 8 && s < 200) begin step(); s++; end
    check("rr_grant_count", glog.size(), 8);
    check("rr_resp_count", rlog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_grant%0d", i), (glog.size() > i) ? glog[i] : -1, i % NUM_CH);
      check($sformatf("rr_resp%0d", i), (rlog.size() > i) ? rlog[i] : -1, i % NUM_CH);
    end
    drain(20);

    // FIPS-197 single job on ch0, 10-cycle core
    rand_lat = 1'b0; core_lat = 10; rlog.delete();
    pend[0] = 1'b1; pkey[0] = FIPS_KEY; ptext[0] = FIPS_PT;
    s = 0;
    while (rlog.size() < 1 && s < 60) begin step(); s++; end
    check("fips_resp_count", rlog.size(), 1);
    check("fips_resp_ch", (rlog.size() > 0) ? rlog[0] : -1, 0);
    check("fips_text", last_text, FIPS_CT);
    check("fips_err", last_err, 0);
    check("fips_ld_lat", ld_cyc - rdy_cyc, 1);
    check("fips_resp_lat", rv_cyc - rdy_cyc, 12);
    drain(5);

    // backpressure: hold resp_ready low 20 cycles, regrant right after handshake
    rand_lat = 1'b1; ready_pct = 0; gen_mode = 2; s = 0;
    while (!resp_valid && s < 60) begin step(); s++; end
    check("bp_resp_reached", resp_valid, 1);
    glog.delete();
    repeat (20) step();
    check("bp_no_grant", glog.size(), 0);
    ready_pct = 100;
    step();
    check("bp_handshake", hs_cyc, cyc);
    step();
    check("bp_regrant", rdy_cyc, hs_cyc + 1);
    drain(30);

    // wrap: ch2 alone sets ptr to 3, then ch2+ch3 -> 3 then 2
    rand_lat = 1'b0; core_lat = 4; glog.delete();
    new_job(2);
    repeat (20) step();
    new_job(2); new_job(3);
    repeat (40) step();
    check("wrap_count", glog.size(), 3);
    check("wrap_g0", (glog.size() > 0) ? glog[0] : -1, 2);
    check("wrap_g1", (glog.size() > 1) ? glog[1] : -1, 3);
    check("wrap_g2", (glog.size() > 2) ? glog[2] : -1, 2);

    // reset mid-BUSY, stale core_done must be ignored, ptr back to 0
    core_lat = 10; glog.delete(); rlog.delete(); ld_cyc = -1;
    new_job(1);
    s = 0;
    while (ld_cyc < 0 && s < 10) begin step(); s++; end
    check("rst_job_loaded", ld_cyc >= 0, 1);
    repeat (3) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (15) step();
    check("rst_no_resp", rlog.size(), 0);
    glog.delete();
    for (int ch = 0; ch < NUM_CH; ch++) new_job(ch);
    repeat (4) step();
    check("rst_ptr0", (glog.size() > 0) ? glog[0] : -1, 0);
    drain(60);

    // randomized traffic
    rand_lat = 1'b1; gen_mode = 1; ready_pct = 70;
    repeat (1500) step();
    drain(40);

    // core never answers in time
    rand_lat = 1'b0; rlog.delete(); ld_cyc = -1;
    core_lat = TO_EN ? 100 : 0;
    new_job(0);
    repeat (160) step();
    if (TO_EN) begin
      check("to_resp_count", rlog.size(), 1);
      check("to_err", last_err, 1);
      check("to_text", last_text, 0);
      check("to_latency", rv_cyc - ld_cyc, TO + 1);
    end else begin
      check("noto_resp_count", rlog.size(), 0);
      check("noto_resp_valid", resp_valid, 0);
    end
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
